// File: rtl/router_fsm_pkg.sv
// Shared types for the 1x3 router control FSM: state encoding, address constants
// and the registered control-output bundle with its state decode.
package router_fsm_pkg;

  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned NUM_FIFOS = 3;

  // Header address 3 has no FIFO behind it; such packets are dropped silently.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_DA  = 3'd0,  // DECODE_ADDRESS
    ST_LFD = 3'd1,  // LOAD_FIRST_DATA
    ST_LD  = 3'd2,  // LOAD_DATA
    ST_FFS = 3'd3,  // FIFO_FULL_STATE
    ST_LAF = 3'd4,  // LOAD_AFTER_FULL
    ST_LP  = 3'd5,  // LOAD_PARITY
    ST_CPE = 3'd6,  // CHECK_PARITY_ERROR
    ST_WTE = 3'd7   // WAIT_TILL_EMPTY
  } state_e;

  typedef struct packed {
    logic detect_addr;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic write_enb_reg;
    logic busy;
  } ctl_t;

  localparam ctl_t CTL_RESET = ctl_t'(8'b1000_0000);

  function automatic ctl_t decode_state(input state_e s);
    ctl_t c;
    c = ctl_t'(8'b0000_0000);
    case (s)
      ST_DA:  c.detect_addr = 1'b1;
      ST_LFD: begin
        c.lfd_state     = 1'b1;
        c.write_enb_reg = 1'b1;
        c.busy          = 1'b1;
      end
      ST_LD: begin
        c.ld_state      = 1'b1;
        c.write_enb_reg = 1'b1;
      end
      ST_FFS: begin
        c.full_state = 1'b1;
        c.busy       = 1'b1;
      end
      ST_LAF: begin
        c.laf_state     = 1'b1;
        c.write_enb_reg = 1'b1;
        c.busy          = 1'b1;
      end
      ST_LP: begin
        c.write_enb_reg = 1'b1;
        c.busy          = 1'b1;
      end
      ST_CPE: begin
        c.rst_int_reg = 1'b1;
        c.busy        = 1'b1;
      end
      ST_WTE: c.busy = 1'b1;
      default: c.detect_addr = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Input-port / router_reg / FIFO control bundle around the router FSM.
// master = environment side, slave = the FSM itself.
interface router_fsm_if;
  import router_fsm_pkg::*;

  logic                  pkt_valid;
  logic [ADDR_W-1:0]     data_in;
  logic                  fifo_full;
  logic [NUM_FIFOS-1:0]  fifo_empty;
  logic [NUM_FIFOS-1:0]  soft_reset;
  logic                  parity_done;
  logic                  low_pkt_valid;

  logic                  detect_addr;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic                  write_enb_reg;
  logic                  busy;
  logic [ADDR_W-1:0]     dest_addr;
  logic                  wait_drop;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, dest_addr, wait_drop
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, dest_addr, wait_drop
  );
endinterface

// File: rtl/router_fsm.sv
// Router control FSM: header decode, payload/parity sequencing, full-FIFO stalls.
// Optional WAIT_TILL_EMPTY drop timer enabled by ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm
  import router_fsm_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 30,
  parameter int unsigned TMR_W        = 6
) (
  input  logic        clk,
  input  logic        rstn,
  router_fsm_if.slave bus
);

  if ((TMR_W < 32'd1) || (WAIT_TIMEOUT < 32'd1) || (WAIT_TIMEOUT > (32'd1 << TMR_W))) begin : g_cfg_check
    $error("router_fsm: TMR_W too narrow for WAIT_TIMEOUT");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  ctl_t              ctl_q, ctl_d;
  logic              wait_drop_q;
  logic              timeout_s;
  logic              sel_soft_rst_s;
  logic              sel_empty_s;

  // Only the soft reset and empty flag of the latched destination matter.
  assign sel_soft_rst_s = bus.soft_reset[dest_q];
  assign sel_empty_s    = bus.fifo_empty[dest_q];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Wait timer: counts WAIT_TILL_EMPTY cycles, zero elsewhere so entry starts at zero.
  always_comb begin
    tmr_d = {TMR_W{1'b0}};
    if (state_q == ST_WTE) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = {TMR_W{1'b0}};
    end
  end

  // Wait timer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr_q <= {TMR_W{1'b0}};
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign timeout_s = (state_q == ST_WTE) && !sel_empty_s && !sel_soft_rst_s &&
                     (tmr_q == TMR_W'(WAIT_TIMEOUT - 32'd1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and destination latch; matching soft reset overrides everything.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if ((state_q != ST_DA) && sel_soft_rst_s) begin
      state_d = ST_DA;
    end else begin
      case (state_q)
        ST_DA: begin
          if (bus.pkt_valid && (bus.data_in != ADDR_INVALID)) begin
            dest_d  = bus.data_in;
            state_d = bus.fifo_empty[bus.data_in] ? ST_LFD : ST_WTE;
          end else begin
            state_d = ST_DA;
          end
        end
        ST_LFD: state_d = ST_LD;
        ST_LD: begin
          if (bus.fifo_full) begin
            state_d = ST_FFS;
          end else if (!bus.pkt_valid) begin
            state_d = ST_LP;
          end else begin
            state_d = ST_LD;
          end
        end
        ST_FFS: begin
          if (!bus.fifo_full) begin
            state_d = ST_LAF;
          end else begin
            state_d = ST_FFS;
          end
        end
        ST_LAF: begin
          if (bus.parity_done) begin
            state_d = ST_DA;
          end else if (bus.low_pkt_valid) begin
            state_d = ST_LP;
          end else begin
            state_d = ST_LD;
          end
        end
        ST_LP: state_d = ST_CPE;
        ST_CPE: begin
          if (bus.fifo_full) begin
            state_d = ST_FFS;
          end else begin
            state_d = ST_DA;
          end
        end
        ST_WTE: begin
          if (sel_empty_s) begin
            state_d = ST_LFD;
          end else if (timeout_s) begin
            state_d = ST_DA;
          end else begin
            state_d = ST_WTE;
          end
        end
        default: state_d = ST_DA;
      endcase
    end
  end

  // Output decode of the upcoming state so the outputs themselves are flops.
  always_comb begin
    ctl_d = decode_state(state_d);
  end

  // State, destination and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_DA;
      dest_q      <= 2'b00;
      ctl_q       <= CTL_RESET;
      wait_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      ctl_q       <= ctl_d;
      wait_drop_q <= timeout_s;
    end
  end

  assign bus.detect_addr   = ctl_q.detect_addr;
  assign bus.lfd_state     = ctl_q.lfd_state;
  assign bus.ld_state      = ctl_q.ld_state;
  assign bus.laf_state     = ctl_q.laf_state;
  assign bus.full_state    = ctl_q.full_state;
  assign bus.rst_int_reg   = ctl_q.rst_int_reg;
  assign bus.write_enb_reg = ctl_q.write_enb_reg;
  assign bus.busy          = ctl_q.busy;
  assign bus.dest_addr     = dest_q;
  assign bus.wait_drop     = wait_drop_q;

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: packets are described by (address, wait, length,
// stall point, stall length) and expanded into per-cycle stimulus plus expected phase.
module tb_router_fsm;

  logic clk;
  logic rstn;
  router_fsm_if bus ();

  router_fsm #(.WAIT_TIMEOUT(4), .TMR_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_HDR, P_PAY, P_STALL, P_REPLAY, P_PAR, P_CHK, P_WAIT} phase_e;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic       pd;
    logic       lpv;
    logic [2:0] sr;
    phase_e     ph;
    logic [1:0] dest;
    logic       wd;
  } cyc_t;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int WTE_D = 3;
`else
  localparam int WTE_D = 5;
`endif

  cyc_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_we  = 0;
  logic [1:0] m_dest = 2'b00;

  function automatic logic [2:0] r3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [1:0] r2();
    return 2'($urandom_range(0, 3));
  endfunction

  // Expected outputs {wait_drop, dest, detect, lfd, ld, laf, full, rst_int, write_enb, busy}.
  function automatic logic [10:0] exp_vec(input phase_e p, input logic [1:0] d, input logic wd);
    logic [7:0] o;
    case (p)
      P_IDLE:   o = 8'b1000_0000;
      P_HDR:    o = 8'b0100_0011;
      P_PAY:    o = 8'b0010_0010;
      P_STALL:  o = 8'b0000_1001;
      P_REPLAY: o = 8'b0001_0011;
      P_PAR:    o = 8'b0000_0011;
      P_CHK:    o = 8'b0000_0101;
      P_WAIT:   o = 8'b0000_0001;
      default:  o = 8'bxxxx_xxxx;
    endcase
    return {wd, d, o};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.wait_drop, bus.dest_addr, bus.detect_addr, bus.lfd_state, bus.ld_state,
            bus.laf_state, bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
  endfunction

  task automatic push(input logic pv, input logic [1:0] din, input logic ff, input logic [2:0] fe,
                      input logic pd, input logic lpv, input logic [2:0] sr,
                      input phase_e ph, input logic wd);
    cyc_t c;
    c.pv = pv; c.din = din; c.ff = ff; c.fe = fe; c.pd = pd; c.lpv = lpv; c.sr = sr;
    c.ph = ph; c.dest = m_dest; c.wd = wd;
    q.push_back(c);
  endtask

  task automatic drive_idle();
    bus.pkt_valid = 1'b0; bus.data_in = 2'b00; bus.fifo_full = 1'b0; bus.fifo_empty = 3'b111;
    bus.soft_reset = 3'b000; bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;
  endtask

  // Expand one packet description into per-cycle stimulus and expected phases.
  task automatic build_packet(input logic [1:0] addr, input int d, input int len,
                              input int full_at, input int full_len, input logic cpe_full);
    logic [2:0] fe;
    if (addr == 2'd3) begin
      for (int i = 0; i < 3; i++) push(1'b1, 2'd3, 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
      push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
      return;
    end
    m_dest = addr;
    fe = r3(); fe[addr] = (d == 0);
    push(1'b1, addr, 1'b0, fe, 1'b0, 1'b0, 3'b000, (d == 0) ? P_HDR : P_WAIT, 1'b0);
    for (int i = 1; i <= d; i++) begin
      fe = r3(); fe[addr] = (i == d);
      push(1'b1, r2(), 1'b0, fe, 1'b0, 1'b0, 3'b000, (i == d) ? P_HDR : P_WAIT, 1'b0);
    end
    push(1'b1, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_PAY, 1'b0);
    for (int b = 1; b <= len; b++) begin
      if (b == full_at) begin
        push(b < len, r2(), 1'b1, r3(), 1'b0, 1'b0, 3'b000, P_STALL, 1'b0);
        for (int i = 1; i <= full_len; i++)
          push(b < len, r2(), i < full_len, r3(), 1'b0, 1'b0, 3'b000,
               (i < full_len) ? P_STALL : P_REPLAY, 1'b0);
        push(b < len, r2(), 1'b0, r3(), 1'b0, b == len, 3'b000, (b == len) ? P_PAR : P_PAY, 1'b0);
      end else begin
        push(b < len, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, (b == len) ? P_PAR : P_PAY, 1'b0);
      end
    end
    push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_CHK, 1'b0);
    if (cpe_full) begin
      push(1'b0, r2(), 1'b1, r3(), 1'b0, 1'b0, 3'b000, P_STALL, 1'b0);
      push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_REPLAY, 1'b0);
      push(1'b0, r2(), 1'b0, r3(), 1'b1, 1'b0, 3'b000, P_IDLE, 1'b0);
    end else begin
      push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
    end
    push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
  endtask

  // Apply queued cycles (all, or at most n) and compare every cycle.
  task automatic play(input string tag, input int n = -1);
    cyc_t c;
    int   k;
    logic [10:0] o, e;
    k = 0;
    while ((q.size() > 0) && ((n < 0) || (k < n))) begin
      c = q.pop_front();
      bus.pkt_valid = c.pv; bus.data_in = c.din; bus.fifo_full = c.ff; bus.fifo_empty = c.fe;
      bus.parity_done = c.pd; bus.low_pkt_valid = c.lpv; bus.soft_reset = c.sr;
      @(posedge clk); #1;
      o = obs();
      e = exp_vec(c.ph, c.dest, c.wd);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b want %b (phase %s)", tag, k, o, e, c.ph.name());
      end
      if (bus.write_enb_reg === 1'b1) n_we++;
      k++;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    n_cmp++;
    if (obs() !== exp_vec(P_IDLE, 2'b00, 1'b0)) begin
      n_err++; $display("FAIL reset_async: got %b want %b", obs(), exp_vec(P_IDLE, 2'b00, 1'b0));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== exp_vec(P_IDLE, 2'b00, 1'b0)) begin
      n_err++; $display("FAIL reset_held: got %b want %b", obs(), exp_vec(P_IDLE, 2'b00, 1'b0));
    end
    @(negedge clk) rstn = 1'b1;
    m_dest = 2'b00;
    for (int i = 0; i < 3; i++) push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
    play("reset_idle");
  endtask

  task automatic test_payload();
    n_we = 0;
    build_packet(2'd2, 0, 7, 0, 0, 1'b0);
    play("payload7");
    n_cmp++;
    if (n_we !== 9) begin
      n_err++; $display("FAIL payload7_we_count: got %0d want %0d", n_we, 9);
    end
  endtask

  task automatic test_full_stall();
    build_packet(2'd2, 0, 5, 3, 2, 1'b0);
    play("full_mid");
    build_packet(2'd0, 0, 4, 4, 1, 1'b0);
    play("full_last_lpv");
    n_we = 0;
    build_packet(2'd1, 0, 2, 0, 0, 1'b1);
    play("full_cpe_parity_done");
    n_cmp++;
    if (n_we !== 5) begin
      n_err++; $display("FAIL cpe_full_we_count: got %0d want %0d", n_we, 5);
    end
  endtask

  task automatic test_wait_empty();
    build_packet(2'd1, WTE_D, 3, 0, 0, 1'b0);
    play("wait_empty");
  endtask

  task automatic test_soft_reset();
    logic [2:0] fe;
    m_dest = 2'd2;
    fe = r3(); fe[2] = 1'b1;
    push(1'b1, 2'd2, 1'b0, fe, 1'b0, 1'b0, 3'b000, P_HDR, 1'b0);
    push(1'b1, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_PAY, 1'b0);
    push(1'b1, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b001, P_PAY, 1'b0);
    push(1'b1, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b011, P_PAY, 1'b0);
    push(1'b1, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b100, P_IDLE, 1'b0);
    push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b111, P_IDLE, 1'b0);
    push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
    play("soft_reset");
  endtask

  task automatic test_timeout();
    logic [2:0] fe;
    m_dest = 2'd0;
    fe = r3(); fe[0] = 1'b0;
    push(1'b1, 2'd0, 1'b0, fe, 1'b0, 1'b0, 3'b000, P_WAIT, 1'b0);
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      fe = r3(); fe[0] = 1'b0;
      push(1'b0, r2(), 1'b0, fe, 1'b0, 1'b0, 3'b000, (i < 4) ? P_WAIT : P_IDLE, i == 4);
    end
`else
    for (int i = 1; i <= 40; i++) begin
      fe = r3(); fe[0] = 1'b0;
      push(1'b0, r2(), 1'b0, fe, 1'b0, 1'b0, 3'b000, P_WAIT, 1'b0);
    end
    push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b001, P_IDLE, 1'b0);
`endif
    push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
    play("wait_timeout");
    n_we = 0;
    build_packet(2'd3, 0, 0, 0, 0, 1'b0);
    play("addr3_drop");
    n_cmp++;
    if (n_we !== 0) begin
      n_err++; $display("FAIL addr3_we_count: got %0d want %0d", n_we, 0);
    end
  endtask

  task automatic test_async_reset();
    build_packet(2'd1, 0, 6, 0, 0, 1'b0);
    play("async_pre", 4);
    q.delete();
    drive_idle();
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== exp_vec(P_IDLE, 2'b00, 1'b0)) begin
      n_err++; $display("FAIL async_mid_packet: got %b want %b", obs(), exp_vec(P_IDLE, 2'b00, 1'b0));
    end
    m_dest = 2'b00;
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 2; i++) push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
    play("async_post");
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      build_packet(r2(), $urandom_range(0, 4), len, $urandom_range(0, len),
                   $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1)
        push(1'b0, r2(), 1'b0, r3(), 1'b0, 1'b0, 3'b000, P_IDLE, 1'b0);
    end
    play("random");
  endtask

  initial begin
    test_reset();
    test_payload();
    test_full_stall();
    test_wait_empty();
    test_soft_reset();
    test_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
